// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a long-latency unit (divider / multi-cycle ALU).
// The long-latency unit hands its result into a one-entry holding buffer.
// The pipeline normally wins the port. If the buffered result is blocked for
// STARVE_LIMIT consecutive cycles, a one-cycle pipeline stall is forced so
// the buffered result can drain. A pipeline write to the same destination
// as the buffered entry supersedes it, and the stale entry is discarded.
//
// Handshake: a result transfers on a rising clk edge where lu_valid and
// lu_ready are both high. lu_valid may be raised or dropped at any time;
// lu_ready depends only on internal state (never on lu_valid), so no
// combinational path runs from lu_valid to lu_ready.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   pipe_wreg/wd/wdata  pipeline writeback request, destination, data
//   lu_valid/wd/wdata   long-latency unit result offer
//   lu_ready            holding buffer empty (registered)
//   rf_we/waddr/wdata   register-file write port
//   stall_req           forced one-cycle pipeline stall (registered)
//   lu_drop             one-cycle pulse: buffered entry superseded (registered)
//   dbg_state           current arbiter state, for checkers
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wreg,
  input  logic [4:0]  pipe_wd,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wd,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic        lu_drop,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // buffer empty
    ST_WAIT  = 2'd1,  // buffer valid, pipeline not stalled
    ST_FORCE = 2'd2   // buffer valid, pipeline stalled this cycle
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]        buf_wd_q, buf_wd_d;
  logic [31:0]       buf_wdata_q, buf_wdata_d;
  logic              lu_ready_q, lu_ready_d;
  logic              stall_req_q, stall_req_d;
  logic              lu_drop_q, lu_drop_d;
  logic [4:0]        last_waddr_q, last_waddr_d;
  logic [31:0]       last_wdata_q, last_wdata_d;

  logic              pipe_req;
  logic              buf_valid;
  logic              supersede;
  logic              grant_pipe;
  logic              grant_buf;
  logic              sel_we;
  logic [4:0]        sel_waddr;
  logic [31:0]       sel_wdata;

  // -------------------------------------------------------------------------
  // Request decode and write-port mux
  // -------------------------------------------------------------------------
  always_comb begin
    pipe_req   = pipe_wreg && (pipe_wd != 5'd0);
    buf_valid  = (state_q != ST_IDLE);
    // A pipeline write to the buffered destination is the newer value.
    supersede  = (state_q == ST_WAIT) && pipe_req && (pipe_wd == buf_wd_q);
    // While FORCE the stalled pipeline re-presents its write next cycle.
    grant_pipe = (state_q != ST_FORCE) && pipe_req;
    grant_buf  = (state_q == ST_FORCE) || (!pipe_req && buf_valid);

    sel_we    = grant_pipe || grant_buf;
    sel_waddr = last_waddr_q;
    sel_wdata = last_wdata_q;
    if (grant_buf) begin
      sel_waddr = buf_wd_q;
      sel_wdata = buf_wdata_q;
    end else if (grant_pipe) begin
      sel_waddr = pipe_wd;
      sel_wdata = pipe_wdata;
    end
  end

  // Port is forced quiet while reset is held, even though the pipeline
  // inputs may still be requesting.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (rst) begin
      rf_we    = sel_we;
      rf_waddr = sel_waddr;
      rf_wdata = sel_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    buf_wd_d     = buf_wd_q;
    buf_wdata_d  = buf_wdata_q;
    lu_drop_d    = 1'b0;
    last_waddr_d = last_waddr_q;
    last_wdata_d = last_wdata_q;

    if (sel_we) begin
      last_waddr_d = sel_waddr;
      last_wdata_d = sel_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        // lu_ready_q is high here; a handshake to r0 completes but stores
        // nothing.
        if (lu_valid && lu_ready_q && (lu_wd != 5'd0)) begin
          state_d     = ST_WAIT;
          buf_wd_d    = lu_wd;
          buf_wdata_d = lu_wdata;
        end
      end
      ST_WAIT: begin
        if (supersede) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
          lu_drop_d  = 1'b1;
        end else if (pipe_req) begin
          if (wait_cnt_q >= LIMIT_M1) begin
            state_d = ST_FORCE;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      end
      ST_FORCE: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    lu_ready_d  = (state_d == ST_IDLE);
    stall_req_d = (state_d == ST_FORCE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      buf_wd_q     <= 5'd0;
      buf_wdata_q  <= 32'd0;
      lu_ready_q   <= 1'b1;
      stall_req_q  <= 1'b0;
      lu_drop_q    <= 1'b0;
      last_waddr_q <= 5'd0;
      last_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      buf_wd_q     <= buf_wd_d;
      buf_wdata_q  <= buf_wdata_d;
      lu_ready_q   <= lu_ready_d;
      stall_req_q  <= stall_req_d;
      lu_drop_q    <= lu_drop_d;
      last_waddr_q <= last_waddr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  assign lu_ready  = lu_ready_q;
  assign stall_req = stall_req_q;
  assign lu_drop   = lu_drop_q;
  assign dbg_state = state_q;

endmodule
